ball_motion: RTL
================

# ball_motion

Generates the ball's on-screen position for the ball-and-paddle game. It advances the ball by a fixed step once per frame tick, reflects it off the top, bottom and right walls and off the paddle on the left edge, and declares a miss when the ball passes the paddle. Its x/y outputs feed the heading-detection stage and the pixel renderer directly.

## Interface
- TICK_DIV, 416667: clk cycles per motion tick (one video frame at 25 MHz / 60 Hz)
- STEP, 2: pixels moved per tick on each axis
- H_RES, 640: playfield width in pixels
- V_RES, 480: playfield height in pixels
- BALL_SIZE, 8: ball side length in pixels
- PADDLE_X, 20: paddle right-edge column; the ball's left edge is clamped here on a hit
- PADDLE_H, 64: paddle height in pixels
- MISS_TICKS, 60: ticks spent in MISS before re-serve
- START_X / START_Y, 60 / 60: serve position
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  serve request, level or pulse, sampled only in IDLE
- paddle_y  in  10  paddle top row
- x  out  10  ball left column
- y  out  10  ball top row
- miss  out  1  one-clk pulse when the ball passes the paddle
- hits  out  8  paddle-hit count, saturates at 255
- busy  out  1  high in MOVE and MISS

## Operation
- Reset (rst=0, asynchronous):
  - x=START_X, y=START_Y
  - Internal direction dx=1, dy=1 (1 = increasing)
  - state=IDLE, miss=0, hits=0, tick counter=0, miss counter=0
- Tick counter free-runs 0..TICK_DIV-1 in every state. `tick` is asserted in the cycle where the count equals TICK_DIV-1.
- States:
  - IDLE: ball held at START_X/START_Y with dx=dy=1. start=1 moves to MOVE on the next clk. hits is not cleared.
  - MOVE: on each tick, both axes are evaluated independently in the same cycle.
    - X axis, dx=1: if x+STEP >= H_RES-BALL_SIZE, then x=H_RES-BALL_SIZE and dx=0; else x+=STEP.
    - X axis, dx=0, x-STEP > PADDLE_X: x-=STEP.
    - X axis, dx=0, x-STEP <= PADDLE_X (compared signed, 11-bit):
      - Hit, when y+BALL_SIZE > paddle_y and y < paddle_y+PADDLE_H: x=PADDLE_X, dx=1, hits+=1 (saturating).
      - Miss, otherwise: x=0, miss=1 for one clk, go to MISS, y frozen.
    - Y axis, dy=1: if y+STEP >= V_RES-BALL_SIZE, then y=V_RES-BALL_SIZE and dy=0; else y+=STEP.
    - Y axis, dy=0: if y <= STEP, then y=0 and dy=1; else y-=STEP.
  - MISS: ball frozen. The miss counter increments on each tick. On the MISS_TICKS-th tick: x=START_X, y=START_Y, dx=dy=1, go to IDLE.
- Arithmetic: all compares and sums use 11-bit signed internals. x/y never leave 0..H_RES-BALL_SIZE and 0..V_RES-BALL_SIZE.
- A corner hit (wall on both axes in one tick) reflects both axes in that tick. A paddle hit and a top/bottom reflection in the same tick are both applied.
- paddle_y is sampled only at the tick edge and is not registered by this block.

## Timing
- x/y/hits update on the clk edge at which tick=1, i.e. they are visible from the following cycle. Tick-to-output latency is 1 clk.
- miss goes high in the same cycle the x=0 update becomes visible and lasts exactly 1 clk.
- start sampled in IDLE: the state is MOVE on the next cycle. The first motion happens at the next tick; the tick counter is not realigned.
- start is ignored in MOVE and MISS.
- Reset mid-operation returns all outputs to their reset values immediately (asynchronous). Counting restarts at 0 after rst rises.

## Test plan
- TICK_DIV=4, start pulse, paddle_y=200. After the first tick, expect x=62, y=62; busy=1 one clk after start.
- Right wall: force a run until x reaches 630. Expect x=632 with dx flipped, then x=630 on the next tick; hits unchanged.
- Top/bottom clamp and corner: with ball at y=471, dy=1, expect y=472 then 470. Approach (632, 472) simultaneously; both axes reflect in one tick.
- Paddle hit: ball descending left at y=60, paddle_y=40. At x crossing 20, expect x=20, hits+1, then x=22. Repeat 260 hits; hits saturates at 255.
- Miss: paddle_y=300, ball at y=60 moving left. Expect x=0, miss=1 for exactly 1 clk, then state MISS; after 60 ticks x=60, y=60, busy=0.
- Reset: assert rst=0 asynchronously mid-MOVE. x=60, y=60, hits=0, miss=0 without waiting for clk; start is required again.

Source files
------------

// File: rtl/ball_motion.sv
// ball_motion: ball position generator for the ball-and-paddle game.
// Advances the ball by STEP pixels per frame tick, reflects it off the
// top/bottom/right walls and the left paddle, and signals a miss when the
// ball gets past the paddle. x/y/hits/miss are all registered outputs.
module ball_motion #(
  parameter int TICK_DIV   = 416667,
  parameter int STEP       = 2,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int BALL_SIZE  = 8,
  parameter int PADDLE_X   = 20,
  parameter int PADDLE_H   = 64,
  parameter int MISS_TICKS = 60,
  parameter int START_X    = 60,
  parameter int START_Y    = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] paddle_y,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       miss,
  output logic [7:0] hits,
  output logic       busy
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MW = (MISS_TICKS > 1) ? $clog2(MISS_TICKS) : 1;

  // 11-bit signed constants so every compare below is a signed compare
  localparam logic signed [10:0] STEP_C   = 11'(STEP);
  localparam logic signed [10:0] X_MAX    = 11'(H_RES - BALL_SIZE);
  localparam logic signed [10:0] Y_MAX    = 11'(V_RES - BALL_SIZE);
  localparam logic signed [10:0] PAD_X    = 11'(PADDLE_X);
  localparam logic signed [10:0] PAD_H    = 11'(PADDLE_H);
  localparam logic signed [10:0] BALL_C   = 11'(BALL_SIZE);
  localparam logic signed [10:0] START_XC = 11'(START_X);
  localparam logic signed [10:0] START_YC = 11'(START_Y);
  localparam logic [CW-1:0]      TICK_END = CW'(TICK_DIV - 1);
  localparam logic [MW-1:0]      MISS_END = MW'(MISS_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MOVE = 2'd1,
    S_MISS = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_nxt;
  logic [CW-1:0]         tick_cnt_r;
  logic [MW-1:0]         miss_cnt_r;
  logic signed [10:0]    x_r;
  logic signed [10:0]    y_r;
  logic                  dx_r;
  logic                  dy_r;
  logic                  miss_r;
  logic [7:0]            hits_r;

  logic                  tick;
  logic                  miss_done;
  logic signed [10:0]    pad_top;
  logic signed [10:0]    x_fwd;
  logic signed [10:0]    x_back;
  logic signed [10:0]    y_fwd;
  logic signed [10:0]    y_back;
  logic signed [10:0]    x_mv;
  logic signed [10:0]    y_mv;
  logic                  dx_mv;
  logic                  dy_mv;
  logic                  hit;
  logic                  lost;

  assign tick      = (tick_cnt_r == TICK_END);
  assign miss_done = (miss_cnt_r == MISS_END);
  assign pad_top   = {1'b0, paddle_y};
  assign x_fwd     = x_r + STEP_C;
  assign x_back    = x_r - STEP_C;
  assign y_fwd     = y_r + STEP_C;
  assign y_back    = y_r - STEP_C;

  // X-axis candidate move: wall reflect, paddle hit, or miss
  always_comb begin
    x_mv  = x_r;
    dx_mv = dx_r;
    hit   = 1'b0;
    lost  = 1'b0;
    if (dx_r) begin
      if (x_fwd >= X_MAX) begin
        x_mv  = X_MAX;
        dx_mv = 1'b0;
      end else begin
        x_mv = x_fwd;
      end
    end else if (x_back > PAD_X) begin
      x_mv = x_back;
    end else if ((y_r + BALL_C > pad_top) && (y_r < pad_top + PAD_H)) begin
      x_mv  = PAD_X;
      dx_mv = 1'b1;
      hit   = 1'b1;
    end else begin
      x_mv = 11'sd0;
      lost = 1'b1;
    end
  end

  // Y-axis candidate move: bottom and top wall reflection
  always_comb begin
    y_mv  = y_r;
    dy_mv = dy_r;
    if (dy_r) begin
      if (y_fwd >= Y_MAX) begin
        y_mv  = Y_MAX;
        dy_mv = 1'b0;
      end else begin
        y_mv = y_fwd;
      end
    end else if (y_r <= STEP_C) begin
      y_mv  = 11'sd0;
      dy_mv = 1'b1;
    end else begin
      y_mv = y_back;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_nxt = S_MOVE;
        else       state_nxt = S_IDLE;
      end
      S_MOVE: begin
        if (tick && lost) state_nxt = S_MISS;
        else              state_nxt = S_MOVE;
      end
      S_MISS: begin
        if (tick && miss_done) state_nxt = S_IDLE;
        else                   state_nxt = S_MISS;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: busy decoded straight from the state register
  always_comb begin
    case (state_r)
      S_MOVE:  busy = 1'b1;
      S_MISS:  busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Tick divider, ball position/direction, miss pulse, hit counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_r <= '0;
      miss_cnt_r <= '0;
      x_r        <= START_XC;
      y_r        <= START_YC;
      dx_r       <= 1'b1;
      dy_r       <= 1'b1;
      miss_r     <= 1'b0;
      hits_r     <= 8'd0;
    end else begin
      tick_cnt_r <= tick ? '0 : tick_cnt_r + CW'(1);
      miss_r     <= 1'b0;
      case (state_r)
        S_IDLE: begin
          x_r        <= START_XC;
          y_r        <= START_YC;
          dx_r       <= 1'b1;
          dy_r       <= 1'b1;
          miss_cnt_r <= '0;
        end
        S_MOVE: begin
          if (tick) begin
            x_r  <= x_mv;
            dx_r <= dx_mv;
            if (lost) begin
              miss_r <= 1'b1;
            end else begin
              y_r  <= y_mv;
              dy_r <= dy_mv;
            end
            if (hit && (hits_r != 8'd255)) hits_r <= hits_r + 8'd1;
          end
        end
        S_MISS: begin
          if (tick) begin
            if (miss_done) begin
              miss_cnt_r <= '0;
              x_r        <= START_XC;
              y_r        <= START_YC;
              dx_r       <= 1'b1;
              dy_r       <= 1'b1;
            end else begin
              miss_cnt_r <= miss_cnt_r + MW'(1);
            end
          end
        end
        default: miss_cnt_r <= '0;
      endcase
    end
  end

  assign x    = x_r[9:0];
  assign y    = y_r[9:0];
  assign miss = miss_r;
  assign hits = hits_r;

endmodule
